// File: rtl/gfx256_rd_arbiter_if.sv
// Requester-side and wishbone-reader-side signals of the gfx256 read arbiter.
// master = arbiter view, slave = requesters plus reader view.
interface gfx256_rd_arbiter_if #(
  parameter int NREQ = 3,
  parameter int MDW  = 256,
  parameter int AW   = 32
);
  logic [NREQ-1:0]        req_i;
  logic [NREQ*AW-1:0]     addr_i;
  logic [NREQ*MDW/8-1:0]  sel_i;
  logic [NREQ-1:0]        ack_o;
  logic [MDW-1:0]         data_o;
  logic [NREQ-1:0]        busy_o;
  logic                   m_request_o;
  logic [AW-1:0]          m_addr_o;
  logic [MDW/8-1:0]       m_sel_o;
  logic                   m_ack_i;
  logic [MDW-1:0]         m_data_i;
  logic                   invalidate_i;

  modport master (
    input  req_i, addr_i, sel_i, m_ack_i, m_data_i, invalidate_i,
    output ack_o, data_o, busy_o, m_request_o, m_addr_o, m_sel_o
  );

  modport slave (
    output req_i, addr_i, sel_i, m_ack_i, m_data_i, invalidate_i,
    input  ack_o, data_o, busy_o, m_request_o, m_addr_o, m_sel_o
  );
endinterface

// File: rtl/gfx256_rd_arbiter.sv
// Round-robin arbiter sharing one wishbone read port between NREQ requesters.
// Optional one-line read buffer: define GFX_RD_ARB_LINE_BUF_EN.
module gfx256_rd_arbiter #(
  parameter int NREQ = 3,
  parameter int MDW  = 256,
  parameter int AW   = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  gfx256_rd_arbiter_if.master bus
);
  localparam int SW   = MDW / 8;
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int OFFW = $clog2(SW);
  localparam logic [GW-1:0] LAST_RST = GW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [GW-1:0]   grant_r, last_r, winner_s;
  logic [GW:0]     sum_s, cand_s;
  logic            found_s, line_hit_s;
  logic            issue_s, hit_s, finish_s;
  logic [AW-1:0]   win_addr_s;
  logic [SW-1:0]   win_sel_s;
  logic [MDW-1:0]  hit_data_s;

  logic [NREQ-1:0] ack_r;
  logic [MDW-1:0]  data_r;
  logic            m_request_r;
  logic [AW-1:0]   m_addr_r;
  logic [SW-1:0]   m_sel_r;

  function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] idx);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Rotating priority search starting just after the last served port.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    sum_s    = '0;
    cand_s   = '0;
    // Walk offsets from farthest to nearest so the nearest requester wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum_s    = {1'b0, last_r} + (GW+1)'(i + 1);
      cand_s   = (sum_s >= (GW+1)'(NREQ)) ? (sum_s - (GW+1)'(NREQ)) : sum_s;
      winner_s = bus.req_i[cand_s[GW-1:0]] ? cand_s[GW-1:0] : winner_s;
      found_s  = found_s | bus.req_i[cand_s[GW-1:0]];
    end
  end

  assign win_addr_s = bus.addr_i[winner_s*AW +: AW];
  assign win_sel_s  = bus.sel_i[winner_s*SW +: SW];

`ifdef GFX_RD_ARB_LINE_BUF_EN
  logic [AW-OFFW-1:0] lb_tag_r;
  logic [MDW-1:0]     lb_data_r;
  logic               lb_valid_r;

  assign line_hit_s = lb_valid_r & ~bus.invalidate_i
                    & (lb_tag_r == win_addr_s[AW-1:OFFW]);
  assign hit_data_s = lb_data_r;

  // Line buffer: filled by every completed read, invalidate wins over fill.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lb_tag_r   <= '0;
      lb_data_r  <= '0;
      lb_valid_r <= 1'b0;
    end else begin
      if (finish_s) begin
        lb_tag_r  <= m_addr_r[AW-1:OFFW];
        lb_data_r <= bus.m_data_i;
      end
      if (bus.invalidate_i) begin
        lb_valid_r <= 1'b0;
      end else if (finish_s) begin
        lb_valid_r <= 1'b1;
      end
    end
  end
`else
  logic unused_invalidate_s;
  assign unused_invalidate_s = bus.invalidate_i;
  assign line_hit_s          = 1'b0;
  assign hit_data_s          = '0;
`endif

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and transaction strobes.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    hit_s       = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s && line_hit_s) begin
          hit_s       = 1'b1;
          state_nxt_s = ST_DONE;
        end else if (found_s) begin
          issue_s     = 1'b1;
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (bus.m_ack_i) begin
          finish_s    = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      // Dead cycle lets the requester drop req_i after its ack.
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Request latch, grant/pointer bookkeeping and read-data return.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_r       <= '0;
      data_r      <= '0;
      m_request_r <= 1'b0;
      m_addr_r    <= '0;
      m_sel_r     <= '1;
      grant_r     <= '0;
      last_r      <= LAST_RST;
    end else begin
      ack_r <= '0;
      if (issue_s) begin
        m_request_r <= 1'b1;
        m_addr_r    <= win_addr_s;
        m_sel_r     <= win_sel_s;
        grant_r     <= winner_s;
      end else if (hit_s) begin
        ack_r   <= onehot(winner_s);
        data_r  <= hit_data_s;
        grant_r <= winner_s;
        last_r  <= winner_s;
      end else if (finish_s) begin
        m_request_r <= 1'b0;
        ack_r       <= onehot(grant_r);
        data_r      <= bus.m_data_i;
        last_r      <= grant_r;
      end
    end
  end

  assign bus.ack_o       = ack_r;
  assign bus.data_o      = data_r;
  assign bus.m_request_o = m_request_r;
  assign bus.m_addr_o    = m_addr_r;
  assign bus.m_sel_o     = m_sel_r;

  for (genvar k = 0; k < NREQ; k++) begin : g_busy
    assign bus.busy_o[k] = (state_r != ST_IDLE) && (grant_r != GW'(k));
  end
endmodule
